// File: rtl/aging_sched_pkg.sv
// Shared types and constants for the aging priority scheduler.
// The sized type and reset constant describe the default four-requester build.
package aging_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int SCHED_N = 4;
    localparam int SCHED_W = $clog2(SCHED_N);

    typedef logic [SCHED_W-1:0] prt_t;

    localparam prt_t PRT_RESET = prt_t'(SCHED_N - 1);

endpackage

// File: rtl/prio_select_comb.sv
// Combinational winner search: requesting entry with the smallest live priority,
// ties resolved toward the highest index.
module prio_select_comb #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] live_prt,
    output logic [W-1:0]   winner,
    output logic           any_valid
);

    logic [W-1:0] best;

    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        best      = '0;
        // Ascending scan with <= lets a later (higher) index take over on a tie.
        for (int i = 0; i < N; i++) begin
            if (req[i] && (!any_valid || (live_prt[i*W +: W] <= best))) begin
                best      = live_prt[i*W +: W];
                winner    = W'(i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aging_priority_scheduler.sv
// Shares one resource among N requesters with aging priorities, holding each grant
// until done or a hold timeout, and driving the port's select/valid.
module aging_priority_scheduler
    import aging_sched_pkg::*;
#(
    parameter  int N        = SCHED_N,
    parameter  int MAX_HOLD = 16,
    localparam int W        = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] base_prt,
    input  logic           done,
    output logic           gnt_valid,
    output logic [W-1:0]   gnt_idx,
    output logic [N-1:0]   gnt_onehot,
    output logic           preempt,
    output logic [N*W-1:0] live_prt
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [W-1:0]  PRT_RST  = W'(N - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    state_e                 state_q, state_d;
    logic [W-1:0]           owner_q;
    logic [HW-1:0]          hold_q;
    logic                   timed_out_q;
    logic [N-1:0][W-1:0]    live_q;
    logic [N-1:0][W-1:0]    base_v;
    logic [W-1:0]           winner;
    logic                   any_valid;
    logic                   grant_evt;
    logic                   release_evt;
    logic                   hold_expired;
    logic                   timeout;

    assign base_v   = base_prt;
    assign live_prt = live_q;

    prio_select_comb #(.N(N)) u_select (
        .req       (req),
        .live_prt  (live_prt),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign grant_evt    = (state_q == IDLE) && any_valid;
    assign release_evt  = (state_q == RELEASE);
    assign hold_expired = (hold_q == HOLD_MAX);
    // A done arriving on the expiry cycle wins, so no preempt is flagged then.
    assign timeout      = (state_q == BUSY) && !done && hold_expired;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = BUSY;
            BUSY:    if (done || hold_expired) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_valid  = (state_q == BUSY);
        gnt_idx    = gnt_valid ? owner_q : '0;
        gnt_onehot = '0;
        if (gnt_valid) gnt_onehot[owner_q] = 1'b1;
        preempt    = release_evt && timed_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= '0;
            hold_q      <= '0;
            timed_out_q <= 1'b0;
        end else begin
            timed_out_q <= timeout;
            if (grant_evt) begin
                owner_q <= winner;
                hold_q  <= HW'(1);
            end else if (state_q == BUSY && state_d == BUSY) begin
                hold_q <= hold_q + HW'(1);
            end else if (state_q != BUSY) begin
                hold_q <= '0;
            end
        end
    end

    // NOTE: the priority bank is small control state, so it is reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) live_q[i] <= PRT_RST;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (grant_evt) begin
                    if ((W'(i) == winner) || !req[i])
                        live_q[i] <= base_v[i];
                    else if (live_q[i] != '0)
                        live_q[i] <= live_q[i] - W'(1);
                end else if (release_evt && !req[i]) begin
                    live_q[i] <= base_v[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_aging_priority_scheduler.sv
// Self-checking bench: directed scenarios plus randomized transactions scored
// against a transaction-level model of the aging rules.
module tb_aging_priority_scheduler;
    import aging_sched_pkg::*;

    localparam int N        = SCHED_N;
    localparam int W        = SCHED_W;
    localparam int MAX_HOLD = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] base_prt;
    logic           done;
    logic           gnt_valid;
    logic [W-1:0]   gnt_idx;
    logic [N-1:0]   gnt_onehot;
    logic           preempt;
    logic [N*W-1:0] live_prt;

    int errors = 0;
    int checks = 0;
    int model_live[N];

    aging_priority_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .base_prt   (base_prt),
        .done       (done),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .preempt    (preempt),
        .live_prt   (live_prt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack_live();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = prt_t'(model_live[i]);
        return v;
    endfunction

    function automatic int model_winner(input logic [N-1:0] r);
        int best = -1;
        for (int i = N - 1; i >= 0; i--)
            if (r[i] && (best < 0 || model_live[i] < model_live[best])) best = i;
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_live[i] = int'(PRT_RESET);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; done = 1'b0;
        @(posedge clk); #1;
        check("reset_live", live_prt, {N{PRT_RESET}});
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One request/grant/release round; d is the BUSY cycle in which done is raised
    // (values above MAX_HOLD mean done never comes and the grant times out).
    task automatic txn(input logic [N-1:0] r, input logic [N*W-1:0] b, input int d,
                       output int won, output logic [N*W-1:0] live_at_grant);
        int w;
        int hold_exp;
        won = -1;
        live_at_grant = '0;
        @(negedge clk);
        req = r; base_prt = b; done = 1'b0;
        if (r == '0) begin
            @(posedge clk); #1;
            check("idle_no_grant", gnt_valid, 0);
            check("idle_live", live_prt, pack_live());
            return;
        end
        w = model_winner(r);
        for (int i = 0; i < N; i++) begin
            if (i == w || !r[i]) model_live[i] = int'(b[i*W +: W]);
            else if (model_live[i] > 0) model_live[i]--;
        end
        @(posedge clk); #1;
        check("grant_valid", gnt_valid, 1);
        check("grant_idx", gnt_idx, w);
        check("grant_onehot", gnt_onehot, 1 << w);
        check("grant_live", live_prt, pack_live());
        won = w;
        live_at_grant = live_prt;
        hold_exp = (d < MAX_HOLD) ? d : MAX_HOLD;
        for (int c = 1; c <= hold_exp; c++) begin
            @(negedge clk);
            check("busy_valid", gnt_valid, 1);
            check("busy_idx", gnt_idx, w);
            check("busy_live", live_prt, pack_live());
            check("busy_preempt", preempt, 0);
            done = (c == d);
        end
        @(posedge clk); #1;
        check("release_valid", gnt_valid, 0);
        check("release_idx", gnt_idx, 0);
        check("release_onehot", gnt_onehot, 0);
        check("release_preempt", preempt, (d > MAX_HOLD) ? 1 : 0);
        check("release_live", live_prt, pack_live());
        @(negedge clk);
        done = 1'b0;
        for (int i = 0; i < N; i++) if (!r[i]) model_live[i] = int'(b[i*W +: W]);
        @(posedge clk); #1;
        check("bubble_valid", gnt_valid, 0);
        check("bubble_preempt", preempt, 0);
        check("bubble_reload_live", live_prt, pack_live());
    endtask

    initial begin
        int won;
        logic [N*W-1:0] snap;
        int exp3[4];
        logic [N-1:0] r;
        logic [N*W-1:0] b;

        // Reset state and quiet idle
        rst = 1'b1; req = '0; done = 1'b0; base_prt = {N{2'd3}};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", gnt_valid, 0);
        check("rst_idx", gnt_idx, 0);
        check("rst_onehot", gnt_onehot, 0);
        check("rst_preempt", preempt, 0);
        check("rst_live", live_prt, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("post_rst_valid", gnt_valid, 0);
            check("post_rst_live", live_prt, 8'hFF);
        end

        // All four requesting with equal base: rotation 3,2,1,0
        for (int k = 0; k < 4; k++) begin
            txn(4'b1111, 8'hFF, 2, won, snap);
            check("t2_order", won, 3 - k);
            if (k == 0) check("t2_first_live", snap, {2'd3, 2'd2, 2'd2, 2'd2});
        end

        // Aging lets a weaker requester catch up and win the tie
        do_reset();
        txn(4'b0010, 8'hFC, 1, won, snap);
        check("t3_preload", won, 1);
        exp3 = '{2, 1, 0, 3};
        for (int k = 0; k < 4; k++) begin
            txn(4'b0011, 8'hFC, 1, won, snap);
            check("t3_order", won, (k < 3) ? 0 : 1);
            check("t3_live1", snap[3:2], exp3[k]);
        end
        check("t3_live0_sat", live_prt[1:0], 0);

        // Hold timeout with preempt, then re-grant of the same requester
        txn(4'b0100, 8'hFF, MAX_HOLD + 2, won, snap);
        check("t4_first", won, 2);
        txn(4'b0100, 8'hFF, MAX_HOLD + 1, won, snap);
        check("t4_regrant", won, 2);

        // done on the expiry cycle is a normal release
        txn(4'b1001, 8'h1B, MAX_HOLD, won, snap);

        // Asynchronous reset in the middle of a grant
        @(negedge clk);
        req = 4'b0100; base_prt = 8'hFF; done = 1'b0;
        @(posedge clk); #1;
        check("t6_granted", gnt_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", gnt_valid, 0);
        check("t6_idx", gnt_idx, 0);
        check("t6_onehot", gnt_onehot, 0);
        check("t6_preempt", preempt, 0);
        check("t6_live", live_prt, 8'hFF);
        @(negedge clk);
        rst = 1'b0; req = '0;
        model_reset();
        txn(4'b0100, 8'hFF, 1, won, snap);
        check("t6_restart", won, 2);

        // Randomized traffic against the model
        for (int k = 0; k < 120; k++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            b = (N*W)'($urandom);
            txn(r, b, $urandom_range(1, MAX_HOLD + 2), won, snap);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
